// File: rtl/nano_mem_responder_if.sv
// NanoCPU memory bus, boot-loader stream and responder status bundled as one port.
// Loader handshake: a word transfers on the posedge where ld_valid && ld_ready are both high;
// ld_data/ld_last are only sampled on that edge, and ld_valid may be held low indefinitely to stall.
interface nano_mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] dataW;
    logic [DATA_W-1:0] dataR;
    logic              ce;
    logic              we;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              reload;
    logic              cpu_hold;
    logic              wr_fault;
    logic [ADDR_W-1:0] fault_addr;
    logic              state;       // debug view of the FSM: 0 = LOAD, 1 = RUN

    modport master (
        output address, dataW, ce, we, ld_valid, ld_data, ld_last, reload,
        input  dataR, ld_ready, cpu_hold, wr_fault, fault_addr, state
    );

    modport slave (
        input  address, dataW, ce, we, ld_valid, ld_data, ld_last, reload,
        output dataR, ld_ready, cpu_hold, wr_fault, fault_addr, state
    );
endinterface

// File: rtl/nano_mem_responder.sv
// Memory-side responder for the NanoCPU: zero-latency-read RAM, boot-load fill while the CPU
// is held in reset, and a write-protected low code region with a sticky fault flag.
module nano_mem_responder #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int PROT_TOP  = 16,
    parameter bit BOOT_LOAD = 1'b1
) (
    input logic                ck,
    input logic                rst,
    nano_mem_responder_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] ST_LOAD  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_RESET = BOOT_LOAD ? ST_RUN ^ 1'b1 : ST_RUN;

    // One extra bit so PROT_TOP == DEPTH protects the whole array.
    localparam logic [ADDR_W:0]   PROT_LIM = (ADDR_W + 1)'(PROT_TOP);
    localparam logic [ADDR_W-1:0] PTR_LAST = (ADDR_W)'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] ld_ptr;
    logic              wr_fault;
    logic [ADDR_W-1:0] fault_addr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_load;
    logic              in_run;
    logic              ld_accept;
    logic              ld_final;
    logic              cpu_wr;
    logic              cpu_prot;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign in_load   = (state == ST_LOAD);
    assign in_run    = (state == ST_RUN);
    assign ld_accept = in_load && bus.ld_valid;
    assign ld_final  = ld_accept && (bus.ld_last || (ld_ptr == PTR_LAST));
    assign cpu_wr    = in_run && bus.ce && bus.we;
    assign cpu_prot  = ({1'b0, bus.address} < PROT_LIM);

    // Single RAM write port shared by the loader (LOAD) and the CPU (RUN).
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ld_ptr;
        mem_wdata = bus.ld_data;
        if (ld_accept) begin
            mem_we = 1'b1;
        end else if (cpu_wr && !cpu_prot) begin
            mem_we    = 1'b1;
            mem_waddr = bus.address;
            mem_wdata = bus.dataW;
        end
    end

    // RAM is never cleared; writes are simply blocked while reset is held.
    always_ff @(posedge ck) begin
        if (rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state  <= ST_RESET;
            ld_ptr <= '0;
        end else if (in_load) begin
            if (ld_final) begin
                state  <= ST_RUN;
                ld_ptr <= '0;
            end else if (ld_accept) begin
                ld_ptr <= ld_ptr + (ADDR_W)'(1);
            end
        end else if (bus.reload) begin
            state  <= ST_LOAD;
            ld_ptr <= '0;
        end
    end

    // A reload clears the fault even if a protected write lands on the same edge.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            wr_fault   <= 1'b0;
            fault_addr <= '0;
        end else if (in_run) begin
            if (bus.reload) begin
                wr_fault   <= 1'b0;
                fault_addr <= '0;
            end else if (cpu_wr && cpu_prot) begin
                wr_fault <= 1'b1;
                if (!wr_fault) begin
                    fault_addr <= bus.address;
                end
            end
        end
    end

    assign bus.dataR      = mem[bus.address];
    assign bus.ld_ready   = in_load;
    assign bus.cpu_hold   = in_load;
    assign bus.wr_fault   = wr_fault;
    assign bus.fault_addr = fault_addr;
    assign bus.state      = state[0];
endmodule
